// File: rtl/sm_prog_sequencer.sv
// sm_prog_sequencer
// Program loader and run controller for the stack machine (SM) core.
// The host fills the instruction memory. Each accepted start resets and releases
// the SM, which then fetches instructions combinationally by its pc. Every SM
// result is queued in a result FIFO. A run ends when the SM signals fin or when
// the watchdog expires.
module sm_prog_sequencer #(
    parameter int IMEM_DEPTH  = 1024,
    parameter int RES_DEPTH   = 16,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [9:0]                 wr_addr,
    input  logic [12:0]                wr_data,
    input  logic [10:0]                prog_len,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic                       timeout,
    output logic                       ovf,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [22:0]                res_data,
    output logic [$clog2(RES_DEPTH):0] res_cnt,
    output logic                       sm_rst_n,
    output logic [12:0]                sm_instr,
    input  logic [9:0]                 sm_pc,
    input  logic                       sm_d_valid,
    input  logic [19:0]                sm_out_data,
    input  logic [2:0]                 sm_err_code,
    input  logic                       sm_fin
);

    localparam int PTR_W = $clog2(RES_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int CYC_W = $clog2(TIMEOUT_CYC + 1);

    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(TIMEOUT_CYC - 1);
    localparam logic [10:0]      LEN_MAX  = 11'(IMEM_DEPTH);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RES_DEPTH);
    // Opcode 111 makes the SM assert fin, so this word parks it past the program end.
    localparam logic [12:0]      END_WORD = 13'b111_0000000000;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RST,
        S_RUN,
        S_DONE
    } state_e;

    // ------------------------------------------------------------------
    // State and storage
    // ------------------------------------------------------------------
    state_e           state_q,    state_d;
    logic [10:0]      len_q,      len_d;
    logic [CYC_W-1:0] cyc_q,      cyc_d;
    logic             sm_rst_n_q, sm_rst_n_d;
    logic             timeout_q,  timeout_d;
    logic             ovf_q,      ovf_d;
    logic [PTR_W-1:0] wr_ptr_q,   wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q,   rd_ptr_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;

    logic [12:0] imem    [IMEM_DEPTH];
    logic [22:0] res_mem [RES_DEPTH];

    // ------------------------------------------------------------------
    // Shared combinational terms
    // ------------------------------------------------------------------
    logic        start_acc;
    logic [10:0] eff_len;
    logic        timeout_hit;
    logic        push_req;
    logic        pop;
    logic        fifo_full;
    logic        push_ok;
    logic        push_drop;

    assign start_acc = start & ~busy;
    assign eff_len   = (prog_len > LEN_MAX) ? LEN_MAX : prog_len;

    assign push_req  = (state_q == S_RUN) & sm_d_valid;
    assign pop       = (cnt_q != '0) & res_ready;
    assign fifo_full = (cnt_q == CNT_FULL);
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign push_ok   = push_req & (~fifo_full | pop);
    assign push_drop = push_req & fifo_full & ~pop;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the values from before the edge regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state, including the watchdog exit from RUN
    always_comb begin
        // NOTE: every signal gets a default before the case, so no path leaves
        // it unassigned and no latch is inferred.
        state_d     = state_q;
        timeout_hit = 1'b0;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start_acc) begin
                    state_d = (eff_len != '0) ? S_RST : S_DONE;
                end
            end
            S_RST: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                // fin has priority over the watchdog when both occur in one cycle
                if (sm_fin) begin
                    state_d = S_DONE;
                end else if (cyc_q == CYC_LAST) begin
                    state_d     = S_DONE;
                    timeout_hit = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FSM: outputs decoded from the current state
    always_comb begin
        busy = (state_q == S_RST) || (state_q == S_RUN);
        done = (state_q == S_DONE);
    end

    // ------------------------------------------------------------------
    // Run control: latched length, cycle counter, SM reset, sticky flags
    // ------------------------------------------------------------------
    // Next values of the run-control registers
    always_comb begin
        len_d = start_acc ? eff_len : len_q;

        cyc_d = cyc_q;
        if (state_q == S_RST) begin
            cyc_d = '0;
        end else if (state_q == S_RUN) begin
            cyc_d = cyc_q + CYC_W'(1);
        end

        // SM runs in RUN and stays released in DONE after a run; a zero-length
        // start from IDLE never releases it.
        unique case (state_d)
            S_RUN:   sm_rst_n_d = 1'b1;
            S_DONE:  sm_rst_n_d = sm_rst_n_q;
            default: sm_rst_n_d = 1'b0;
        endcase

        timeout_d = timeout_q;
        if (start_acc) begin
            timeout_d = 1'b0;
        end else if (timeout_hit) begin
            timeout_d = 1'b1;
        end

        ovf_d = ovf_q;
        if (start_acc) begin
            ovf_d = 1'b0;
        end else if (push_drop) begin
            ovf_d = 1'b1;
        end
    end

    // Run-control registers; sm_rst_n drops asynchronously with rst_n
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q      <= '0;
            cyc_q      <= '0;
            sm_rst_n_q <= 1'b0;
            timeout_q  <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            len_q      <= len_d;
            cyc_q      <= cyc_d;
            sm_rst_n_q <= sm_rst_n_d;
            timeout_q  <= timeout_d;
            ovf_q      <= ovf_d;
        end
    end

    assign sm_rst_n = sm_rst_n_q;
    assign timeout  = timeout_q;
    assign ovf      = ovf_q;

    // ------------------------------------------------------------------
    // Instruction memory
    // ------------------------------------------------------------------
    // Host writes, accepted only while the SM is not being driven
    // NOTE: the memory arrays have no reset; their contents are defined by
    // writes, and the loaded program survives rst_n.
    always_ff @(posedge clk) begin
        if (wr_en && !busy) begin
            imem[wr_addr] <= wr_data;
        end
    end

    // Instruction fetch for the SM, padded with END past the program length
    always_comb begin
        if ({1'b0, sm_pc} < len_q) begin
            sm_instr = imem[sm_pc];
        end else begin
            sm_instr = END_WORD;
        end
    end

    // ------------------------------------------------------------------
    // Result FIFO
    // ------------------------------------------------------------------
    // Pointer and occupancy update; an accepted start flushes the queue
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (start_acc) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            unique case ({push_ok, pop})
                2'b10:   cnt_d = cnt_q + CNT_W'(1);
                2'b01:   cnt_d = cnt_q - CNT_W'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // FIFO pointer and occupancy registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // FIFO storage write of captured SM results
    always_ff @(posedge clk) begin
        if (push_ok) begin
            res_mem[wr_ptr_q] <= {sm_err_code, sm_out_data};
        end
    end

    assign res_valid = (cnt_q != '0);
    assign res_cnt   = cnt_q;
    assign res_data  = res_mem[rd_ptr_q];

endmodule

// File: doc/sm_prog_sequencer.md
Name: sm_prog_sequencer

Overview:
Program loader and run controller for the stack machine (SM) core. The host writes a program of 13-bit instructions into an internal instruction memory. The block then resets and releases the SM and serves instructions combinationally from the SM's pc. It captures every d_valid result {err_code, out_data} into a result FIFO and signals completion on SM fin or on a watchdog timeout. It sits between the host/bus side and the SM instance.

Parameters:
IMEM_DEPTH, 1024, instruction memory entries; must match the 10-bit SM pc space.
RES_DEPTH, 16, result FIFO entries; power of 2.
TIMEOUT_CYC, 1000000, maximum RUN cycles before forced stop.

Ports:
clk  in  1  clock, all logic on posedge.
rst_n  in  1  asynchronous active-low reset.
wr_en  in  1  host instruction write strobe; ignored while busy=1.
wr_addr  in  10  instruction memory write address.
wr_data  in  13  instruction {opcode[12:10], operand[9:0]}.
prog_len  in  11  program length in instructions; sampled on accepted start.
start  in  1  run request, single-cycle; ignored while busy=1.
busy  out  1  1 in RST and RUN states.
done  out  1  level; 1 in DONE until the next accepted start.
timeout  out  1  sticky; set when the run ended by watchdog; cleared on start.
ovf  out  1  sticky; a result was dropped because the FIFO was full; cleared on start.
res_valid  out  1  FIFO not empty.
res_ready  in  1  host pop; a pop occurs when res_valid & res_ready.
res_data  out  23  FIFO head {err_code[22:20], out_data[19:0]}.
res_cnt  out  $clog2(RES_DEPTH)+1  FIFO occupancy.
sm_rst_n  out  1  SM reset, active-low, registered.
sm_instr  out  13  instruction to the SM.
sm_pc  in  10  SM program counter.
sm_d_valid  in  1  SM result valid.
sm_out_data  in  20  SM result value.
sm_err_code  in  3  SM error code.
sm_fin  in  1  SM finished.

Behaviour:
- Reset: state IDLE. sm_rst_n=0; busy, done, timeout, ovf, res_valid = 0; res_cnt=0; FIFO pointers=0; cycle counter=0. Instruction memory is not reset.
- Effective length: len = min(prog_len, IMEM_DEPTH), latched on accepted start.
- sm_instr (combinational): imem[sm_pc] if sm_pc < len, else the END word 13'b111_0000000000. SM opcode 111 asserts fin.
- Memory write: with wr_en=1 and busy=0, imem[wr_addr] <= wr_data at posedge. Writes during busy are dropped.
- States:
  - IDLE: sm_rst_n=0. Accepted start goes to RST if len>0, or directly to DONE (done=1, no SM activity) if len=0.
  - RST: exactly one cycle, sm_rst_n=0. Cycle counter is cleared. Next state is RUN.
  - RUN: sm_rst_n=1 (registered, so it first goes high on the first RUN cycle). The counter increments every cycle. sm_fin=1 goes to DONE. If the counter reaches TIMEOUT_CYC-1 with no fin, next state is DONE with timeout<=1. If fin and timeout occur in the same cycle, fin wins and timeout stays 0.
  - DONE: sm_rst_n=1 (SM frozen by the END instruction), done=1. Accepted start goes to RST (len>0) or stays in DONE (len=0), clearing timeout and ovf.
- Start acceptance: in IDLE or DONE only. On acceptance, the FIFO is flushed (pointers and count zero) in the same edge.
- Capture: in RUN, a posedge with sm_d_valid=1 pushes {sm_err_code, sm_out_data}. sm_d_valid is ignored in IDLE, RST and DONE. A result arriving in the same cycle as sm_fin is still captured.
- FIFO:
  - Push when full with no pop: data is dropped and ovf<=1.
  - Push and pop in the same cycle when full: both accepted, res_cnt unchanged, no ovf.
  - Push and pop in the same cycle when empty: push accepted, pop ignored (res_valid was 0).
  - Pointers wrap modulo RES_DEPTH. res_data is valid whenever res_valid=1.
- Async reset mid-RUN: immediate return to the reset state; sm_rst_n drops asynchronously.

Test Plan:
- Load {PUSH 3, PUSH 4, ADD}, prog_len=3, start. Then: busy=1; one-cycle sm_rst_n=0 pulse; sm_instr follows sm_pc; sm_instr=13'h1C00 at pc=3. FIFO holds {err, 20'd7} with the SM's err value. done=1 after sm_fin.
- prog_len=0, start. Then: done=1 on the next cycle, busy never set, sm_rst_n stays 0, res_valid=0.
- RES_DEPTH=4, 6 results with res_ready=0. Then: res_cnt=4, ovf=1, head equals the first result. Repeat with res_ready=1 while full: no ovf, all 6 results read in order.
- sm_fin held 0 with TIMEOUT_CYC=100. Then: DONE exactly 100 RUN cycles after entering RUN, with timeout=1. A new start clears timeout and ovf and flushes the FIFO.
- wr_en during RUN to address 0. Then: imem[0] unchanged, and a read-back in the next run serves the original word. start during RUN is ignored.
- rst_n asserted mid-RUN with 2 results queued. Then: immediate sm_rst_n=0, res_cnt=0, done=0, state IDLE. The program is still present for the next start.
